// File: rtl/fft_bin_indexer_if.sv
// Streaming bus between an FFT core and the bin indexer.
// The slave modport is the indexer's view; the master modport is the FFT/consumer side.
interface fft_bin_indexer_if #(
  parameter int BIN_W   = 32,
  parameter int CHAN_W  = 8,
  parameter int FRAME_W = 32
);
  logic               fft_valid;
  logic               fft_sop;
  logic               out_valid;
  logic [BIN_W-1:0]   bin_num;
  logic [CHAN_W-1:0]  chan_num;
  logic               out_sof;
  logic               out_eof;
  logic [FRAME_W-1:0] frame_num;
  logic               sync_err;

  modport slave (
    input  fft_valid, fft_sop,
    output out_valid, bin_num, chan_num, out_sof, out_eof, frame_num, sync_err
  );

  modport master (
    output fft_valid, fft_sop,
    input  out_valid, bin_num, chan_num, out_sof, out_eof, frame_num, sync_err
  );
endinterface

// File: rtl/fft_bin_indexer.sv
// Tags each FFT output sample with channel, bin and frame position, resyncing on stray sop.
// Define FFT_BIN_FRAME_COUNT_EN to build the frame counter; otherwise frame_num is tied to 0.
module fft_bin_indexer #(
  parameter int BINS     = 512,
  parameter int CHANNELS = 1,
  parameter int BIN_W    = 32,
  parameter int CHAN_W   = 8,
  parameter int FRAME_W  = 32
) (
  input  logic             clk,
  input  logic             areset_n,
  fft_bin_indexer_if.slave bus
);
  typedef enum logic {HUNT, RUN} state_e;

  state_e            state_q;
  // Position the next sample is expected to occupy
  logic [CHAN_W-1:0] chan_q;
  logic [BIN_W-1:0]  bin_q;

  logic              out_valid_q;
  logic              out_sof_q;
  logic              out_eof_q;
  logic              sync_err_q;
  logic [CHAN_W-1:0] chan_num_q;
  logic [BIN_W-1:0]  bin_num_q;

  logic              accept;
  logic              atStart;
  logic              resync;
  logic              isLast;
  logic [CHAN_W-1:0] tagChan;
  logic [BIN_W-1:0]  tagBin;
  logic [CHAN_W-1:0] chan_d;
  logic [BIN_W-1:0]  bin_d;

  always_comb begin
    accept  = bus.fft_valid && (state_q == RUN || bus.fft_sop);
    atStart = (chan_q == '0) && (bin_q == '0);
    resync  = (state_q == RUN) && bus.fft_valid && bus.fft_sop && !atStart;
    tagChan = chan_q;
    tagBin  = bin_q;
    if (bus.fft_sop) begin
      tagChan = '0;
      tagBin  = '0;
    end
    isLast = (tagChan == CHAN_W'(CHANNELS - 1)) && (tagBin == BIN_W'(BINS - 1));
    chan_d = tagChan + CHAN_W'(1);
    bin_d  = tagBin;
    if (tagChan == CHAN_W'(CHANNELS - 1)) begin
      chan_d = '0;
      bin_d  = isLast ? '0 : tagBin + BIN_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!areset_n) begin
      state_q     <= HUNT;
      chan_q      <= '0;
      bin_q       <= '0;
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      out_eof_q   <= 1'b0;
      sync_err_q  <= 1'b0;
      chan_num_q  <= '0;
      bin_num_q   <= '0;
    end else begin
      out_valid_q <= accept;
      sync_err_q  <= resync;
      if (accept) begin
        state_q    <= RUN;
        chan_q     <= chan_d;
        bin_q      <= bin_d;
        chan_num_q <= tagChan;
        bin_num_q  <= tagBin;
        out_sof_q  <= (tagChan == '0) && (tagBin == '0);
        out_eof_q  <= isLast;
      end
    end
  end

`ifdef FFT_BIN_FRAME_COUNT_EN
  // frame_q is the frame the next in-order sample belongs to
  logic [FRAME_W-1:0] frame_q;
  logic [FRAME_W-1:0] frame_num_q;
  logic [FRAME_W-1:0] tagFrame;

  always_comb begin
    tagFrame = frame_q;
    if (state_q == HUNT) begin
      tagFrame = '0;
    end else if (resync) begin
      tagFrame = frame_q + FRAME_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!areset_n) begin
      frame_q     <= '0;
      frame_num_q <= '0;
    end else if (accept) begin
      frame_num_q <= tagFrame;
      frame_q     <= isLast ? tagFrame + FRAME_W'(1) : tagFrame;
    end
  end

  assign bus.frame_num = frame_num_q;
`else
  assign bus.frame_num = '0;
`endif

  assign bus.out_valid = out_valid_q;
  assign bus.out_sof   = out_sof_q;
  assign bus.out_eof   = out_eof_q;
  assign bus.sync_err  = sync_err_q;
  assign bus.chan_num  = chan_num_q;
  assign bus.bin_num   = bin_num_q;
endmodule

// File: tb/tb_fft_bin_indexer.sv
// Directed bench for fft_bin_indexer with BINS=4, CHANNELS=2; frame expectations
// follow FFT_BIN_FRAME_COUNT_EN (0 throughout when the macro is undefined).
module tb_fft_bin_indexer;
  localparam int BINS     = 4;
  localparam int CHANNELS = 2;
`ifdef FFT_BIN_FRAME_COUNT_EN
  localparam bit frameEn = 1'b1;
`else
  localparam bit frameEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic areset_n = 1'b0;
  int   checkCount = 0;
  int   passCount = 0;

  fft_bin_indexer_if #(.BIN_W(32), .CHAN_W(8), .FRAME_W(32)) bus ();

  fft_bin_indexer #(
    .BINS(BINS), .CHANNELS(CHANNELS), .BIN_W(32), .CHAN_W(8), .FRAME_W(32)
  ) dut (
    .clk(clk),
    .areset_n(areset_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] expFrame(input int f);
    return frameEn ? 32'(f) : 32'd0;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
  endtask

  // Drive one cycle of input, then sample just after the edge that consumed it
  task automatic applyStimulus(input logic v, input logic s);
    @(negedge clk);
    bus.fft_valid = v;
    bus.fft_sop   = s;
    @(posedge clk);
    #1;
  endtask

  task automatic checkSample(input string tag, input int c, input int b, input logic sof,
                             input logic eof, input int f, input logic err);
    checkOutput({tag, ".valid"}, 64'(bus.out_valid), 64'd1);
    checkOutput({tag, ".chan"},  64'(bus.chan_num), 64'(c));
    checkOutput({tag, ".bin"},   64'(bus.bin_num), 64'(b));
    checkOutput({tag, ".sof"},   64'(bus.out_sof), 64'(sof));
    checkOutput({tag, ".eof"},   64'(bus.out_eof), 64'(eof));
    checkOutput({tag, ".frame"}, 64'(bus.frame_num), 64'(expFrame(f)));
    checkOutput({tag, ".err"},   64'(bus.sync_err), 64'(err));
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".valid"}, 64'(bus.out_valid), 64'd0);
    checkOutput({tag, ".chan"},  64'(bus.chan_num), 64'd0);
    checkOutput({tag, ".bin"},   64'(bus.bin_num), 64'd0);
    checkOutput({tag, ".sof"},   64'(bus.out_sof), 64'd0);
    checkOutput({tag, ".eof"},   64'(bus.out_eof), 64'd0);
    checkOutput({tag, ".frame"}, 64'(bus.frame_num), 64'd0);
    checkOutput({tag, ".err"},   64'(bus.sync_err), 64'd0);
  endtask

  initial begin
    bus.fft_valid = 1'b1;
    bus.fft_sop   = 1'b1;
    areset_n      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkAllZero("reset");

    // Release with valid low: the valid seen under reset must not leak out
    @(negedge clk);
    areset_n      = 1'b1;
    bus.fft_valid = 1'b0;
    bus.fft_sop   = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("postResetValid", 64'(bus.out_valid), 64'd0);

    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 1'b0);
      checkOutput($sformatf("hunt%0d.valid", k), 64'(bus.out_valid), 64'd0);
    end

    // Two contiguous frames; a sop on the second frame's first sample is accepted silently
    for (int k = 0; k < 16; k++) begin
      applyStimulus(1'b1, (k == 0) || (k == 8));
      checkSample($sformatf("run%0d", k), k % 2, (k / 2) % 4, (k % 8) == 0, (k % 8) == 7, k / 8, 1'b0);
    end

    // Frame 2 with idle cycles between samples; tags hold through the gaps
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b1, 1'b0);
      checkSample($sformatf("gap%0d", k), k % 2, (k / 2) % 4, (k % 8) == 0, (k % 8) == 7, 2, 1'b0);
      applyStimulus(1'b0, 1'b0);
      checkOutput($sformatf("gapIdle%0d.valid", k), 64'(bus.out_valid), 64'd0);
      checkOutput($sformatf("gapIdle%0d.chan", k), 64'(bus.chan_num), 64'(k % 2));
      checkOutput($sformatf("gapIdle%0d.bin", k), 64'(bus.bin_num), 64'((k / 2) % 4));
    end

    // Frame 3: stray sop on the 5th sample forces a resync into frame 4
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 1'b0);
      checkSample($sformatf("pre%0d", k), k % 2, (k / 2) % 4, k == 0, 1'b0, 3, 1'b0);
    end
    applyStimulus(1'b1, 1'b1);
    checkSample("resync", 0, 0, 1'b1, 1'b0, 4, 1'b1);
    applyStimulus(1'b0, 1'b0);
    checkOutput("resyncPulse.err", 64'(bus.sync_err), 64'd0);
    checkOutput("resyncPulse.valid", 64'(bus.out_valid), 64'd0);
    applyStimulus(1'b1, 1'b0);
    checkSample("post1", 1, 0, 1'b0, 1'b0, 4, 1'b0);
    applyStimulus(1'b1, 1'b0);
    checkSample("post2", 0, 1, 1'b0, 1'b0, 4, 1'b0);

    // Mid-frame reset with valid held high
    @(negedge clk);
    areset_n      = 1'b0;
    bus.fft_valid = 1'b1;
    bus.fft_sop   = 1'b0;
    @(posedge clk);
    #1;
    checkAllZero("midReset");
    @(negedge clk);
    areset_n      = 1'b1;
    bus.fft_valid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("midRelease.valid", 64'(bus.out_valid), 64'd0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("midHunt.valid", 64'(bus.out_valid), 64'd0);
    applyStimulus(1'b1, 1'b1);
    checkSample("restart0", 0, 0, 1'b1, 1'b0, 0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    checkSample("restart1", 1, 0, 1'b0, 1'b0, 0, 1'b0);
    applyStimulus(1'b0, 1'b0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule
